// File: rtl/tx_frame_ctrl.sv
// Byte FIFO feeding a UART-style serialiser: start bit, 8 data bits LSB first, stop bit.
// A frame drains the whole buffer back to back, then pulses tfin for one cycle.
module tx_frame_ctrl #(
  parameter int DEPTH      = 16,
  parameter int BIT_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 datain,
  input  logic                       en,
  input  logic                       start,
  input  logic                       abort,
  output logic                       txd,
  output logic                       busy,
  output logic                       tbnfout,
  output logic                       tfin,
  output logic [$clog2(DEPTH+1)-1:0] countout
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic [CW-1:0]   cyc;
  logic [2:0]      bit_idx, bit_nxt;
  logic [7:0]      shreg, cur_byte;
  logic            wr, bit_end, byte_end, txd_d;

  assign bit_end  = (cyc == CW'(BIT_CYCLES - 1));
  assign byte_end = (state == STOP) && bit_end;
  assign wr       = en && tbnfout;
  assign countout = count;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && (count != '0 || wr)) state_nxt = START;
        START:   if (bit_end) state_nxt = DATA;
        DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
        STOP:    if (bit_end) state_nxt = (count == CNTW'(1)) ? DONE : START;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == START) || (state == DATA) || (state == STOP);
    tfin     = (state == DONE);
    tbnfout  = !busy && (count != CNTW'(DEPTH));
    bit_nxt  = (state == DATA) ? bit_idx + 3'(bit_end) : 3'd0;
    // On the START->DATA edge the shift register is not loaded yet, so bit 0 comes from the buffer.
    cur_byte = (state == DATA) ? shreg : mem[rd_ptr];
    case (state_nxt)
      START:   txd_d = 1'b0;
      DATA:    txd_d = cur_byte[bit_nxt];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= datain;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txd     <= 1'b1;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cyc     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      txd <= txd_d;
      if (abort) begin
        count   <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        cyc     <= '0;
        bit_idx <= '0;
      end else begin
        cyc     <= (busy && !bit_end) ? cyc + CW'(1) : '0;
        bit_idx <= bit_nxt;
        if (state == START && bit_end) shreg <= mem[rd_ptr];
        if (wr) begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count + CNTW'(1);
        end else if (byte_end) begin
          count  <= count - CNTW'(1);
        end
        if (byte_end) rd_ptr <= rd_ptr + AW'(1);
        // Frame fully drained: rewind both pointers so the next frame starts at slot 0.
        if (state_nxt == DONE) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
        end
      end
    end
  end

endmodule
